// File: rtl/gsim_pkg.sv
// Shared constants and state encodings for the GSIM x-burst collector.
package gsim_pkg;

   localparam int unsigned N  = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned PW = $clog2(N);

   localparam int SAT_MAX = 32767;
   localparam int SAT_MIN = -32768;

   typedef enum logic [1:0] {WIdle, WFill, WDrop} w_state_e;
   typedef enum logic       {RIdle, RDrain}       r_state_e;

endpackage

// File: rtl/gsim_sat_round.sv
// Combinational Q16.16 -> int16 round-half-up with saturation, sign-extended to DW.
module gsim_sat_round
   import gsim_pkg::*;
(
   input  logic [DW-1:0] i_x,
   output logic [DW-1:0] o_y
);

   logic signed [DW:0] w_sum;
   int                 w_val;
   logic        [15:0] w_q;

   // One guard bit so that x near +max cannot wrap when the half LSB is added.
   assign w_sum = $signed({i_x[DW-1], i_x}) + $signed((DW+1)'(32'h8000));
   assign w_val = int'(w_sum >>> 16);

   always_comb begin
      w_q = w_val[15:0];
      if (w_val > SAT_MAX) begin
         w_q = 16'h7FFF;
      end else if (w_val < SAT_MIN) begin
         w_q = 16'h8000;
      end
   end

   assign o_y = {{(DW-16){w_q[15]}}, w_q};

endmodule

// File: rtl/gsim_x_collector.sv
// Ping-pong capture of GSIM x bursts, drained over valid/ready.
// Optional GSIM_COLLECT_SAT_EN converts each word to a saturated int16 on write.
module gsim_x_collector
   import gsim_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_x_valid,
   input  logic [DW-1:0] i_x_in,
   output logic          o_m_valid,
   input  logic          i_m_ready,
   output logic [DW-1:0] o_m_data,
   output logic [PW-1:0] o_m_index,
   output logic          o_m_last,
   output logic          o_ovf,
   output logic          o_frm_err
);

   w_state_e      r_wstate;
   r_state_e      r_rstate;
   logic [DW-1:0] r_mem [2][N];
   logic [1:0]    r_full;
   logic          r_wr_bank, r_rd_bank;
   logic [PW-1:0] r_wr_ptr, r_rd_ptr;
   logic          r_m_valid, r_m_last, r_ovf, r_frm_err;
   logic [DW-1:0] r_m_data;
   logic [PW-1:0] r_m_index;

   logic [DW-1:0] w_wdata;
   logic          w_wr_en, w_wr_done, w_rd_done;
   logic [PW-1:0] w_wr_addr, w_rd_next;

`ifdef GSIM_COLLECT_SAT_EN
   gsim_sat_round u_sat (
      .i_x (i_x_in),
      .o_y (w_wdata)
   );
`else
   assign w_wdata = i_x_in;
`endif

   assign w_wr_en   = i_x_valid && (((r_wstate == WIdle) && !r_full[r_wr_bank]) ||
                                    (r_wstate == WFill));
   assign w_wr_addr = (r_wstate == WIdle) ? '0 : r_wr_ptr;
   assign w_wr_done = (r_wstate == WFill) && i_x_valid && (r_wr_ptr == PW'(N-1));
   assign w_rd_done = (r_rstate == RDrain) && i_m_ready && (r_rd_ptr == PW'(N-1));
   assign w_rd_next = r_rd_ptr + 1'b1;

   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_bank][w_wr_addr] <= w_wdata;
      end
   end

   // Only the completion of a fill makes a bank visible to the reader.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_full <= '0;
      end else begin
         if (w_wr_done) r_full[r_wr_bank] <= 1'b1;
         if (w_rd_done) r_full[r_rd_bank] <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wstate  <= WIdle;
         r_wr_ptr  <= '0;
         r_wr_bank <= 1'b0;
         r_ovf     <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         unique case (r_wstate)
            WIdle: begin
               if (i_x_valid) begin
                  if (!r_full[r_wr_bank]) begin
                     r_wr_ptr <= PW'(1);
                     r_wstate <= WFill;
                  end else begin
                     r_ovf    <= 1'b1;
                     r_wstate <= WDrop;
                  end
               end
            end
            WFill: begin
               if (i_x_valid) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (w_wr_done) begin
                     r_wr_bank <= ~r_wr_bank;
                     r_wstate  <= WIdle;
                  end
               end else begin
                  r_frm_err <= 1'b1;
                  r_wstate  <= WIdle;
               end
            end
            WDrop: begin
               if (!i_x_valid) r_wstate <= WIdle;
            end
            default: r_wstate <= WIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rstate  <= RIdle;
         r_rd_ptr  <= '0;
         r_rd_bank <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_index <= '0;
         r_m_last  <= 1'b0;
      end else begin
         unique case (r_rstate)
            RIdle: begin
               if (r_full[r_rd_bank]) begin
                  r_rstate  <= RDrain;
                  r_rd_ptr  <= '0;
                  r_m_valid <= 1'b1;
                  r_m_data  <= r_mem[r_rd_bank][0];
                  r_m_index <= '0;
                  r_m_last  <= 1'b0;
               end
            end
            RDrain: begin
               if (i_m_ready) begin
                  if (w_rd_done) begin
                     r_rd_bank <= ~r_rd_bank;
                     r_m_valid <= 1'b0;
                     r_m_last  <= 1'b0;
                     r_rstate  <= RIdle;
                  end else begin
                     r_rd_ptr  <= w_rd_next;
                     r_m_data  <= r_mem[r_rd_bank][w_rd_next];
                     r_m_index <= w_rd_next;
                     r_m_last  <= (w_rd_next == PW'(N-1));
                  end
               end
            end
            default: r_rstate <= RIdle;
         endcase
      end
   end

   assign o_m_valid = r_m_valid;
   assign o_m_data  = r_m_data;
   assign o_m_index = r_m_index;
   assign o_m_last  = r_m_last;
   assign o_ovf     = r_ovf;
   assign o_frm_err = r_frm_err;

endmodule
